// File: rtl/spi_download_rx.sv
// SPI responder for the MCU->core file download channel: oversamples the SPI pins in clk_sys,
// decodes command/data bytes into ioctl byte writes and answers a one-byte status read.
module spi_download_rx #(
    parameter int ADDR_W      = 25,
    parameter int START_ADDR  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_di,
    output logic              spi_do,
    output logic              spi_do_oe,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              ioctl_overflow
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        CMD_TX,
        CMD_DAT,
        CMD_IDX,
        CMD_STAT,
        IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] ss_sr;
    logic [SYNC_STAGES-1:0] di_sr;
    logic                   sck_d;
    logic [6:0]             sreg;
    logic [2:0]             bcnt;
    logic [7:0]             tx;

    logic       sck_sync;
    logic       ss_sync;
    logic       di_sync;
    logic       sck_rise;
    logic       sck_fall;
    logic [7:0] byte_in;

    assign sck_sync = sck_sr[SYNC_STAGES-1];
    assign ss_sync  = ss_sr[SYNC_STAGES-1];
    assign di_sync  = di_sr[SYNC_STAGES-1];
    assign sck_rise = sck_sync & ~sck_d;
    assign sck_fall = ~sck_sync & sck_d;
    assign byte_in  = {sreg, di_sync};

    assign spi_do_oe = ~ss_sync;
    assign spi_do    = (state == CMD_STAT) && tx[7];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_sr         <= '0;
            ss_sr          <= '1;
            di_sr          <= '0;
            sck_d          <= 1'b0;
            sreg           <= '0;
            bcnt           <= '0;
            tx             <= '0;
            state          <= IDLE;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= START;
            ioctl_dout     <= '0;
            ioctl_overflow <= 1'b0;
        end else begin
            sck_sr   <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            ss_sr    <= {ss_sr[SYNC_STAGES-2:0], spi_ss};
            di_sr    <= {di_sr[SYNC_STAGES-2:0], spi_di};
            sck_d    <= sck_sync;
            ioctl_wr <= 1'b0;

            if (ioctl_wr) begin
                if (ioctl_addr == '1)
                    ioctl_overflow <= 1'b1;
                ioctl_addr <= ioctl_addr + 1'b1;
            end

            if (ss_sync) begin
                bcnt  <= '0;
                state <= IDLE;
            end else begin
                // The falling edge closing a byte (bcnt back at 0) must not shift, or the
                // status MSB would be gone before the MCU samples it on the next rising edge.
                if (sck_fall && bcnt != 3'd0)
                    tx <= {tx[6:0], 1'b0};

                if (sck_rise) begin
                    sreg <= byte_in[6:0];
                    bcnt <= bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        case (state)
                            IDLE: begin
                                case (byte_in)
                                    8'h53: state <= CMD_TX;
                                    8'h54: state <= CMD_DAT;
                                    8'h55: state <= CMD_IDX;
                                    8'h5A: begin
                                        state <= CMD_STAT;
                                        tx    <= {ioctl_download, ioctl_overflow, 6'b0};
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                            CMD_TX: begin
                                if (byte_in == 8'hFF) begin
                                    ioctl_download <= 1'b1;
                                    ioctl_addr     <= START;
                                    ioctl_overflow <= 1'b0;
                                end else if (byte_in == 8'h00) begin
                                    ioctl_download <= 1'b0;
                                end
                                state <= IGNORE;
                            end
                            CMD_DAT: begin
                                if (ioctl_download) begin
                                    ioctl_dout <= byte_in;
                                    ioctl_wr   <= 1'b1;
                                end
                            end
                            CMD_IDX: begin
                                ioctl_index <= byte_in;
                                state       <= IGNORE;
                            end
                            CMD_STAT: state <= IGNORE;
                            default:  state <= IGNORE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_download_rx.sv
// Self-checking bench for spi_download_rx: bit-banged SPI host plus a write scoreboard
// consumed on every clock while stimulus runs.
module tb_spi_download_rx;

    localparam int AW   = 4;
    localparam int HALF = 6;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          spi_sck;
    logic          spi_ss;
    logic          spi_di;
    logic          spi_do;
    logic          spi_do_oe;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_overflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t  exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic prev_wr      = 1'b0;

    spi_download_rx #(
        .ADDR_W(AW),
        .START_ADDR(0),
        .SYNC_STAGES(2)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .spi_sck(spi_sck),
        .spi_ss(spi_ss),
        .spi_di(spi_di),
        .spi_do(spi_do),
        .spi_do_oe(spi_do_oe),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_overflow(ioctl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Every elapsed clock passes through here so each write strobe is scored against the queue.
    task automatic run_cycles(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (ioctl_wr === 1'b1) begin
                tests_run++;
                if (prev_wr === 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL wr_width: strobe high on consecutive cycles, required one cycle");
                end else if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL wr_unexpected: got addr=%0h dout=%02h, required no write", ioctl_addr, ioctl_dout);
                end else begin
                    e = exp_q.pop_front();
                    if ({ioctl_addr, ioctl_dout} !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL wr_data: got addr=%0h dout=%02h, required addr=%0h dout=%02h",
                                 ioctl_addr, ioctl_dout, e.addr, e.data);
                    end
                end
            end
            prev_wr = ioctl_wr;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_di = b[i];
            run_cycles(HALF);
            rx[i]   = spi_do;
            spi_sck = 1'b1;
            run_cycles(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] rx;
        send_bits(b, 8, rx);
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        run_cycles(HALF);
    endtask

    task automatic ss_high();
        run_cycles(HALF);
        spi_ss = 1'b1;
        spi_di = 1'b0;
        run_cycles(8);
    endtask

    task automatic frame2(input logic [7:0] a, input logic [7:0] b);
        ss_low();
        send_byte(a);
        send_byte(b);
        ss_high();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        spi_di  = 1'b0;
        run_cycles(4);
        tests_run++;
        if ({ioctl_download, ioctl_wr, ioctl_overflow, spi_do, spi_do_oe} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %05b, required 00000",
                     {ioctl_download, ioctl_wr, ioctl_overflow, spi_do, spi_do_oe});
        end
        tests_run++;
        if ({ioctl_addr, ioctl_index, ioctl_dout} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got addr=%0h index=%02h dout=%02h, required all 0",
                     ioctl_addr, ioctl_index, ioctl_dout);
        end
        reset = 1'b0;
        run_cycles(4);
    endtask

    task automatic test_download();
        logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        frame2(8'h53, 8'hFF);
        tests_run++;
        if (ioctl_download !== 1'b1 || ioctl_addr !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL dl_start: got download=%b addr=%0h, required 1 and 0", ioctl_download, ioctl_addr);
        end
        ss_low();
        send_byte(8'h54);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: AW'(i), data: data[i]});
            send_byte(data[i]);
        end
        ss_high();
        tests_run++;
        if (exp_q.size() != 0 || ioctl_addr !== 4'h4) begin
            tests_failed++;
            $display("[TB] FAIL dl_end: got pending=%0d addr=%0h, required 0 and 4", exp_q.size(), ioctl_addr);
        end
    endtask

    task automatic test_index_end();
        frame2(8'h55, 8'h07);
        frame2(8'h53, 8'h00);
        tests_run++;
        if (ioctl_index !== 8'h07) begin
            tests_failed++;
            $display("[TB] FAIL index: got %02h, required 07", ioctl_index);
        end
        tests_run++;
        if (ioctl_download !== 1'b0 || ioctl_addr !== 4'h4) begin
            tests_failed++;
            $display("[TB] FAIL dl_stop: got download=%b addr=%0h, required 0 and 4", ioctl_download, ioctl_addr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        frame2(8'h53, 8'hFF);
        ss_low();
        send_byte(8'h54);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back('{addr: AW'(i), data: 8'(8'hA0 + i)});
            send_byte(8'(8'hA0 + i));
            if (i == 14) begin
                tests_run++;
                if (ioctl_overflow !== 1'b0 || ioctl_addr !== 4'hF) begin
                    tests_failed++;
                    $display("[TB] FAIL pre_wrap: got overflow=%b addr=%0h, required 0 and f", ioctl_overflow, ioctl_addr);
                end
            end
        end
        ss_high();
        tests_run++;
        if (ioctl_overflow !== 1'b1 || ioctl_addr !== 4'h1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL wrap: got overflow=%b addr=%0h pending=%0d, required 1, 1, 0",
                     ioctl_overflow, ioctl_addr, exp_q.size());
        end
        ss_low();
        send_byte(8'h5A);
        send_bits(8'h00, 8, rx);
        ss_high();
        tests_run++;
        if (rx !== 8'hC0) begin
            tests_failed++;
            $display("[TB] FAIL status_ovf: got %02h, required c0", rx);
        end
        frame2(8'h53, 8'hFF);
        tests_run++;
        if (ioctl_overflow !== 1'b0 || ioctl_addr !== 4'h0 || ioctl_download !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL restart: got overflow=%b addr=%0h download=%b, required 0, 0, 1",
                     ioctl_overflow, ioctl_addr, ioctl_download);
        end
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        ss_low();
        send_byte(8'h54);
        send_bits(8'hF0, 5, rx);
        ss_high();
        tests_run++;
        if (ioctl_addr !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL partial_drop: got addr=%0h, required 0", ioctl_addr);
        end
        ss_low();
        send_byte(8'h54);
        exp_q.push_back('{addr: 4'h0, data: 8'hAB});
        send_byte(8'hAB);
        ss_high();
        tests_run++;
        if (ioctl_addr !== 4'h1 || ioctl_dout !== 8'hAB || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL partial_next: got addr=%0h dout=%02h pending=%0d, required 1, ab, 0",
                     ioctl_addr, ioctl_dout, exp_q.size());
        end
    endtask

    task automatic test_status();
        logic [7:0] rx;
        ss_low();
        tests_run++;
        if (spi_do_oe !== 1'b1 || spi_do !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oe_low_ss: got oe=%b do=%b, required 1 and 0", spi_do_oe, spi_do);
        end
        send_byte(8'h5A);
        send_bits(8'h00, 8, rx);
        ss_high();
        tests_run++;
        if (rx !== 8'h80) begin
            tests_failed++;
            $display("[TB] FAIL status: got %02h, required 80", rx);
        end
        tests_run++;
        if (spi_do_oe !== 1'b0 || spi_do !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oe_high_ss: got oe=%b do=%b, required 0 and 0", spi_do_oe, spi_do);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        ss_low();
        send_byte(8'h54);
        send_bits(8'h99, 3, rx);
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
        ss_high();
        tests_run++;
        if (ioctl_download !== 1'b0 || ioctl_addr !== 4'h0 || ioctl_index !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got download=%b addr=%0h index=%02h, required 0, 0, 00",
                     ioctl_download, ioctl_addr, ioctl_index);
        end
        frame2(8'h53, 8'hFF);
        ss_low();
        send_byte(8'h54);
        exp_q.push_back('{addr: 4'h0, data: 8'h5C});
        send_byte(8'h5C);
        ss_high();
        tests_run++;
        if (ioctl_download !== 1'b1 || ioctl_addr !== 4'h1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset: got download=%b addr=%0h pending=%0d, required 1, 1, 0",
                     ioctl_download, ioctl_addr, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_download();
        test_index_end();
        test_wrap();
        test_partial();
        test_status();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running at 2ms, required completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
